// File: rtl/eth_reply_pkg.sv
// eth_reply_pkg: header constants, byte offsets, reply types and ones-complement helpers
package eth_reply_pkg;
    localparam logic [15:0] ETH_ARP = 16'h0806;
    localparam logic [15:0] ETH_IPV4 = 16'h0800;
    localparam logic [7:0] IP_VER_IHL = 8'h45;
    localparam logic [7:0] PROTO_ICMP = 8'd1;
    localparam logic [7:0] PROTO_UDP = 8'd17;
    localparam logic [7:0] ICMP_ECHO_REQ = 8'd8;
    localparam logic [15:0] ICMP_TYPE_ADJ = 16'h0800;
    localparam logic [15:0] ARP_REQ = 16'd1;
    localparam logic [15:0] ARP_REPLY = 16'd2;
    localparam int OFF_ETH_DST = 0;
    localparam int OFF_ETH_SRC = 6;
    localparam int OFF_ETH_TYPE = 12;
    localparam int OFF_IP = 14;
    localparam int OFF_TTL = 22;
    localparam int OFF_PROTO = 23;
    localparam int OFF_IP_CSUM = 24;
    localparam int OFF_IP_SRC = 26;
    localparam int OFF_IP_DST = 30;
    localparam int OFF_L4 = 34;
    localparam int OFF_ARP_OPER = 20;
    localparam int OFF_ARP_SHA = 22;
    localparam int OFF_ARP_SPA = 28;
    localparam int OFF_ARP_THA = 32;
    localparam int OFF_ARP_TPA = 38;
    typedef enum logic [1:0] {RT_ARP = 2'd0, RT_ICMP = 2'd1, RT_UDP = 2'd2} reply_type_e;
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction
    function automatic logic [15:0] fold20(input logic [19:0] raw);
        logic [16:0] s;
        s = {1'b0, raw[15:0]} + {13'd0, raw[19:16]};
        return s[15:0] + {15'd0, s[16]};
    endfunction
endpackage

// File: rtl/eth_csum16_fold.sv
// eth_csum16_fold: double end-around-carry fold of a 20-bit ones-complement sum
module eth_csum16_fold
    import eth_reply_pkg::*;
(
    input  logic [19:0] raw,
    output logic [15:0] folded
);
    assign folded = fold20(raw);
endmodule

// File: rtl/ethernet_reply_header_engine.sv
// ethernet_reply_header_engine: two-stage ARP/ICMP/UDP reply header builder with backpressure
module ethernet_reply_header_engine
    import eth_reply_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP = 32'hC0000186,
    parameter int HEAD_BYTES = 42,
    parameter logic [2:0] EN_MASK = 3'b111,
    parameter logic [7:0] REPLY_TTL = 8'd64,
    parameter logic [15:0] UDP_CSUM = 16'h0000,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_head_valid,
    output logic                    o_head_ready,
    input  logic [HEAD_BYTES*8-1:0] i_head,
    output logic                    o_reply_valid,
    input  logic                    i_reply_ready,
    output logic [HEAD_BYTES*8-1:0] o_reply,
    output logic [1:0]              o_reply_type,
    output logic                    o_drop,
    output logic [CNT_W-1:0]        o_cnt_arp,
    output logic [CNT_W-1:0]        o_cnt_icmp,
    output logic [CNT_W-1:0]        o_cnt_udp,
    output logic [CNT_W-1:0]        o_cnt_drop
);
    localparam int W = HEAD_BYTES * 8;

    function automatic int msb(input int k);
        return (HEAD_BYTES - k) * 8 - 1;
    endfunction

    logic en, accept, is_ip, ip_for_us, hit_arp, hit_icmp, hit_udp, match, s1_valid;
    logic [19:0] raw_sum, s1_sum;
    logic [15:0] ip_csum;
    logic [W-1:0] s1_head, reply;
    reply_type_e cls, s1_type;

    assign en = !o_reply_valid || i_reply_ready;
    assign o_head_ready = en;
    assign accept = i_head_valid && en;

    // The IP sum already reflects the reply header: TTL replaced, checksum field zeroed
    always_comb begin
        is_ip = i_head[msb(OFF_ETH_TYPE) -: 16] == ETH_IPV4 && i_head[msb(OFF_IP) -: 8] == IP_VER_IHL;
        ip_for_us = is_ip && i_head[msb(OFF_IP_DST) -: 32] == FPGA_IP;
        hit_arp = EN_MASK[0] && i_head[msb(OFF_ETH_TYPE) -: 16] == ETH_ARP
                  && i_head[msb(OFF_ARP_OPER) -: 16] == ARP_REQ && i_head[msb(OFF_ARP_TPA) -: 32] == FPGA_IP;
        hit_icmp = EN_MASK[1] && ip_for_us && i_head[msb(OFF_PROTO) -: 8] == PROTO_ICMP
                   && i_head[msb(OFF_L4) -: 8] == ICMP_ECHO_REQ;
        hit_udp = EN_MASK[2] && ip_for_us && i_head[msb(OFF_PROTO) -: 8] == PROTO_UDP;
        match = hit_arp || hit_icmp || hit_udp;
        cls = hit_arp ? RT_ARP : hit_icmp ? RT_ICMP : RT_UDP;
        raw_sum = {4'd0, REPLY_TTL, i_head[msb(OFF_PROTO) -: 8]};
        for (int i = 0; i < 10; i++)
            if (i != 4 && i != 5) raw_sum = raw_sum + {4'd0, i_head[msb(OFF_IP + 2 * i) -: 16]};
    end

    eth_csum16_fold u_fold (.raw(s1_sum), .folded(ip_csum));

    always_comb begin
        reply = s1_head;
        reply[msb(OFF_ETH_DST) -: 48] = s1_head[msb(OFF_ETH_SRC) -: 48];
        if (s1_type == RT_ARP) begin
            reply[msb(OFF_ETH_SRC) -: 48] = FPGA_MAC;
            reply[msb(OFF_ARP_OPER) -: 16] = ARP_REPLY;
            reply[msb(OFF_ARP_SHA) -: 48] = FPGA_MAC;
            reply[msb(OFF_ARP_SPA) -: 32] = FPGA_IP;
            reply[msb(OFF_ARP_THA) -: 48] = s1_head[msb(OFF_ARP_SHA) -: 48];
            reply[msb(OFF_ARP_TPA) -: 32] = s1_head[msb(OFF_ARP_SPA) -: 32];
        end else begin
            reply[msb(OFF_ETH_SRC) -: 48] = s1_head[msb(OFF_ETH_DST) -: 48];
            reply[msb(OFF_TTL) -: 8] = REPLY_TTL;
            reply[msb(OFF_IP_CSUM) -: 16] = ~ip_csum;
            reply[msb(OFF_IP_SRC) -: 32] = s1_head[msb(OFF_IP_DST) -: 32];
            reply[msb(OFF_IP_DST) -: 32] = s1_head[msb(OFF_IP_SRC) -: 32];
            if (s1_type == RT_ICMP) begin
                reply[msb(OFF_L4) -: 8] = 8'd0;
                reply[msb(OFF_L4 + 2) -: 16] = ones_add(s1_head[msb(OFF_L4 + 2) -: 16], ICMP_TYPE_ADJ);
            end else begin
                reply[msb(OFF_L4) -: 16] = s1_head[msb(OFF_L4 + 2) -: 16];
                reply[msb(OFF_L4 + 2) -: 16] = s1_head[msb(OFF_L4) -: 16];
                reply[msb(OFF_L4 + 6) -: 16] = UDP_CSUM;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_type <= RT_ARP;
            s1_head <= '0;
            s1_sum <= '0;
            o_reply_valid <= 1'b0;
            o_reply <= '0;
            o_reply_type <= 2'd0;
            o_drop <= 1'b0;
            o_cnt_arp <= '0;
            o_cnt_icmp <= '0;
            o_cnt_udp <= '0;
            o_cnt_drop <= '0;
        end else begin
            o_drop <= accept && !match;
            o_cnt_drop <= o_cnt_drop + CNT_W'(accept && !match);
            if (en) begin
                s1_valid <= accept && match;
                if (accept && match) begin
                    s1_head <= i_head;
                    s1_type <= cls;
                    s1_sum <= raw_sum;
                end
                o_reply_valid <= s1_valid;
                if (s1_valid) begin
                    o_reply <= reply;
                    o_reply_type <= s1_type;
                end
                o_cnt_arp <= o_cnt_arp + CNT_W'(s1_valid && s1_type == RT_ARP);
                o_cnt_icmp <= o_cnt_icmp + CNT_W'(s1_valid && s1_type == RT_ICMP);
                o_cnt_udp <= o_cnt_udp + CNT_W'(s1_valid && s1_type == RT_UDP);
            end
        end
endmodule

// File: tb/tb_ethernet_reply_header_engine.sv
// tb_ethernet_reply_header_engine: directed vectors with hand-computed reply fields
module tb_ethernet_reply_header_engine;
    localparam logic [47:0] MAC = 48'h211abcdef112;
    localparam logic [31:0] IP = 32'hC0A800C7;

    logic clk = 0, rst = 1, head_valid = 0, reply_ready = 1;
    logic [335:0] head = '0;
    logic head_ready, reply_valid, drop;
    logic [335:0] reply;
    logic [1:0] reply_type;
    logic [15:0] cnt_arp, cnt_icmp, cnt_udp, cnt_drop;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    ethernet_reply_header_engine #(.FPGA_IP(IP)) dut (
        .i_clk(clk), .i_reset(rst), .i_head_valid(head_valid), .o_head_ready(head_ready),
        .i_head(head), .o_reply_valid(reply_valid), .i_reply_ready(reply_ready),
        .o_reply(reply), .o_reply_type(reply_type), .o_drop(drop),
        .o_cnt_arp(cnt_arp), .o_cnt_icmp(cnt_icmp), .o_cnt_udp(cnt_udp), .o_cnt_drop(cnt_drop));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] f(input int k, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[55:0], reply[(42 - k - i) * 8 - 1 -: 8]};
        return r;
    endfunction

    function automatic logic [335:0] put(input logic [335:0] h, input int k, input int n, input logic [47:0] v);
        for (int i = 0; i < n; i++) h[(42 - k - i) * 8 - 1 -: 8] = v[(n - 1 - i) * 8 +: 8];
        return h;
    endfunction

    function automatic logic [335:0] mk_arp(input logic [31:0] tpa);
        logic [335:0] h = '0;
        h = put(h, 0, 6, 48'hffffffffffff);
        h = put(h, 6, 6, 48'h020000000001);
        h = put(h, 12, 6, 48'h080600010800);
        h = put(h, 18, 4, 48'h000006040001);
        h = put(h, 22, 6, 48'h020000000001);
        h = put(h, 28, 4, 48'h0000C0000101);
        return put(h, 38, 4, {16'd0, tpa});
    endfunction

    function automatic logic [335:0] mk_ip(input logic [15:0] len, input logic [7:0] ttl, input logic [7:0] proto,
                                           input logic [15:0] csum, input logic [31:0] src,
                                           input logic [31:0] l4a, input logic [31:0] l4b);
        logic [335:0] h = '0;
        h = put(h, 0, 6, MAC);
        h = put(h, 6, 6, 48'h020000000002);
        h = put(h, 12, 6, {32'h08004500, len});
        h = put(h, 18, 6, {32'h00004000, ttl, proto});
        h = put(h, 24, 6, {csum, src});
        h = put(h, 30, 4, {16'd0, IP});
        h = put(h, 34, 4, {16'd0, l4a});
        return put(h, 38, 4, {16'd0, l4b});
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [335:0] h);
        head = h;
        head_valid = 1;
        step;
        head_valid = 0;
    endtask

    initial begin
        logic [335:0] held;
        logic [63:0] t;
        logic [15:0] got [$];
        logic seen;
        int idx;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(reply_valid), 64'd0);
        chk("rst_reply", 64'(|reply), 64'd0);
        chk("rst_type", 64'(reply_type), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_cnts", {cnt_arp, cnt_icmp, cnt_udp, cnt_drop}, 64'd0);
        rst = 0;
        step;
        chk("rst_ready", 64'(head_ready), 64'd1);
        // ARP request for our address
        push(mk_arp(IP));
        chk("arp_n1_valid", 64'(reply_valid), 64'd0);
        step;
        chk("arp_n2_valid", 64'(reply_valid), 64'd1);
        chk("arp_type", 64'(reply_type), 64'd0);
        chk("arp_eth_dst", f(0, 6), 64'h020000000001);
        chk("arp_eth_src", f(6, 6), 64'(MAC));
        chk("arp_copy", f(12, 8), 64'h0806000108000604);
        chk("arp_oper", f(20, 2), 64'h0002);
        chk("arp_sha", f(22, 6), 64'(MAC));
        chk("arp_spa", f(28, 4), 64'(IP));
        chk("arp_tha", f(32, 6), 64'h020000000001);
        chk("arp_tpa", f(38, 4), 64'hC0000101);
        chk("arp_cnt", 64'(cnt_arp), 64'd1);
        step;
        chk("arp_once", 64'(reply_valid), 64'd0);
        // ICMP echo, checksum 0x1234 and carry-wrapping 0xF800
        push(mk_ip(16'h0054, 8'h40, 8'h01, 16'h0000, 32'hC0A80002, 32'h08001234, 32'h00010001));
        step;
        chk("icmp_valid", 64'(reply_valid), 64'd1);
        chk("icmp_type", 64'(reply_type), 64'd1);
        chk("icmp_eth_dst", f(0, 6), 64'h020000000002);
        chk("icmp_eth_src", f(6, 6), 64'(MAC));
        chk("icmp_ip_csum", f(24, 2), 64'hB88F);
        chk("icmp_ip_src", f(26, 4), 64'(IP));
        chk("icmp_ip_dst", f(30, 4), 64'hC0A80002);
        chk("icmp_type_code", f(34, 2), 64'h0000);
        chk("icmp_csum", f(36, 2), 64'h1A34);
        chk("icmp_rest", f(38, 4), 64'h00010001);
        push(mk_ip(16'h0054, 8'h40, 8'h01, 16'h0000, 32'hC0A80002, 32'h0800F800, 32'h00010001));
        step;
        chk("icmp_wrap", f(36, 2), 64'h0001);
        chk("icmp_cnt", 64'(cnt_icmp), 64'd2);
        // UDP datagram to our address
        push(mk_ip(16'h0073, 8'h80, 8'h11, 16'hABCD, 32'hC0A80001, 32'h12340035, 32'h005F9999));
        step;
        chk("udp_valid", 64'(reply_valid), 64'd1);
        chk("udp_type", 64'(reply_type), 64'd2);
        chk("udp_ip_copy", f(14, 8), 64'h4500007300004000);
        chk("udp_ttl_proto", f(22, 2), 64'h4011);
        chk("udp_ip_csum", f(24, 2), 64'hB861);
        chk("udp_ips", f(26, 8), {IP, 32'hC0A80001});
        chk("udp_ports", f(34, 4), 64'h00351234);
        chk("udp_len_csum", f(38, 4), 64'h005F0000);
        // Drops: wrong ARP target, TCP
        push(mk_arp(32'hC0A80099));
        chk("drop1_pulse", 64'(drop), 64'd1);
        step;
        chk("drop1_once", 64'(drop), 64'd0);
        chk("drop1_noreply", 64'(reply_valid), 64'd0);
        push(mk_ip(16'h0028, 8'h40, 8'h06, 16'h0000, 32'hC0A80001, 32'h12340050, 32'h00000000));
        chk("drop2_pulse", 64'(drop), 64'd1);
        step;
        chk("drop2_noreply", 64'(reply_valid), 64'd0);
        chk("drop_cnt", 64'(cnt_drop), 64'd2);
        chk("drop_cnt_arp", 64'(cnt_arp), 64'd1);
        // Four back-to-back UDP with downstream stalled for three cycles
        idx = 0;
        held = '0;
        for (int c = 0; c < 12; c++) begin
            reply_ready = !(c >= 2 && c < 5);
            head_valid = idx < 4;
            head = mk_ip(16'h0073, 8'h80, 8'h11, 16'h0000, 32'hC0A80001,
                         {16'h1000 + 16'(idx), 16'h0035}, 32'h005F9999);
            #1;
            if (c == 2) held = reply;
            if (c >= 2 && c < 5) chk("bp_ready_low", 64'(head_ready), 64'd0);
            if (c >= 3 && c <= 5) chk("bp_stable", 64'(reply !== held || !reply_valid), 64'd0);
            if (reply_valid && reply_ready) begin
                t = f(36, 2);
                got.push_back(t[15:0]);
            end
            if (head_valid && head_ready) idx++;
            step;
        end
        head_valid = 0;
        reply_ready = 1;
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("bp_order", 64'(got[i]), 64'h1000 + 64'(i));
        chk("bp_cnt_udp", 64'(cnt_udp), 64'd5);
        // Reset with two headers in flight
        head = mk_ip(16'h0073, 8'h80, 8'h11, 16'h0000, 32'hC0A80001, 32'h20000035, 32'h005F9999);
        head_valid = 1;
        step;
        step;
        head_valid = 0;
        chk("rst_inflight", 64'(reply_valid), 64'd1);
        rst = 1;
        #1;
        chk("rst_mid_valid", 64'(reply_valid), 64'd0);
        chk("rst_mid_reply", 64'(|reply), 64'd0);
        chk("rst_mid_cnts", {cnt_arp, cnt_icmp, cnt_udp, cnt_drop}, 64'd0);
        step;
        step;
        rst = 0;
        seen = 0;
        repeat (4) begin
            step;
            seen = seen | reply_valid;
        end
        chk("rst_no_reply", 64'(seen), 64'd0);
        chk("rst_end_cnts", {cnt_arp, cnt_icmp, cnt_udp, cnt_drop}, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
